ram_arbiter: RTL

- Two-requester round-robin arbiter and sequencer for the single-port 1024x8 async-read RAM (addr/data_in/wr/cs, combinational data_out).
- Serialises read and write requests from two clients onto the RAM pins and returns registered read data with a valid strobe.
- Optionally clears the whole array after reset.
- Sits between the RAM instance and the client logic.

---
 rtl/ram_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-client round-robin arbiter/sequencer for a single-port async-read RAM; one access per 2 cycles.
// Define RAM_INIT_EN to fill the whole array with INIT_VALUE after reset before accepting requests.
module ram_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 8,
   parameter int MEM_DEPTH  = 1024,
   parameter int INIT_VALUE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_wr,
   output logic              mem_cs,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              init_done
);

   // Elaboration-time parameter sanity checks.
   if (MEM_DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("ram_arbiter: MEM_DEPTH does not fit in ADDR_W");
   end
   if (INIT_VALUE < 0 || INIT_VALUE >= (1 << DATA_W)) begin : g_bad_init
      $error("ram_arbiter: INIT_VALUE does not fit in DATA_W");
   end

`ifdef RAM_INIT_EN
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_INIT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ACCESS} state_t;
`endif

   state_t state;
   logic   cur;          // client owning the access in flight
   logic   last_served;
   logic   pick0;
   logic   pick1;

`ifdef RAM_INIT_EN
   logic [ADDR_W-1:0] init_addr;
   logic              init_phase;
   logic              init_done_q;
   assign init_done = init_done_q;
`else
   assign init_done = 1'b1;
`endif

   // On a tie the client that was not served last wins.
   assign pick0 = req0 & (~req1 | last_served);
   assign pick1 = req1 & ~pick0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
         rdata0      <= '0;
         rdata1      <= '0;
         mem_addr    <= '0;
         mem_din     <= '0;
         mem_wr      <= 1'b0;
         mem_cs      <= 1'b0;
         cur         <= 1'b0;
         last_served <= 1'b1;
`ifdef RAM_INIT_EN
         state       <= S_INIT;
         init_addr   <= '0;
         init_phase  <= 1'b0;
         init_done_q <= 1'b0;
`else
         state       <= S_IDLE;
`endif
      end else begin
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick0 | pick1) begin
                  state  <= S_ACCESS;
                  cur    <= pick1;
                  gnt0   <= pick0;
                  gnt1   <= pick1;
                  mem_cs <= 1'b1;
                  if (pick1) begin
                     mem_wr   <= we1;
                     mem_addr <= addr1;
                     mem_din  <= we1 ? wdata1 : '0;
                  end else begin
                     mem_wr   <= we0;
                     mem_addr <= addr0;
                     mem_din  <= we0 ? wdata0 : '0;
                  end
               end
            end
            S_ACCESS: begin
               // mem_wr still reflects the access type during this cycle.
               if (!mem_wr) begin
                  if (cur) begin
                     rdata1  <= mem_dout;
                     rvalid1 <= 1'b1;
                  end else begin
                     rdata0  <= mem_dout;
                     rvalid0 <= 1'b1;
                  end
               end
               mem_cs      <= 1'b0;
               mem_wr      <= 1'b0;
               last_served <= cur;
               state       <= S_IDLE;
            end
`ifdef RAM_INIT_EN
            S_INIT: begin
               if (!init_phase) begin
                  mem_cs     <= 1'b1;
                  mem_wr     <= 1'b1;
                  mem_addr   <= init_addr;
                  mem_din    <= DATA_W'(INIT_VALUE);
                  init_phase <= 1'b1;
               end else begin
                  mem_cs     <= 1'b0;
                  mem_wr     <= 1'b0;
                  init_phase <= 1'b0;
                  if (init_addr == ADDR_W'(MEM_DEPTH - 1)) begin
                     init_done_q <= 1'b1;
                     state       <= S_IDLE;
                  end else begin
                     init_addr <= init_addr + 1'b1;
                  end
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
